// File: rtl/interrupt_controller_pkg.sv
// interrupt_controller_pkg: shared state encoding and default constants for the interrupt controller
package interrupt_controller_pkg;

    localparam int          ADDR_W_DEF      = 12;
    localparam logic [11:0] VECTOR_ADDR_DEF = 12'h002;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FLUSH  = 3'd1,
        S_VECTOR = 3'd2,
        S_ISR    = 3'd3,
        S_RETURN = 3'd4
    } state_t;

endpackage

// File: rtl/interrupt_controller_if.sv
// interrupt_controller_if: decode-side strobes in, fetch-side redirect/flush controls out
interface interrupt_controller_if
    import interrupt_controller_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              instr_valid_d;
    logic              ien_d;
    logic              iof_d;
    logic              rti_d;
    logic              branch_d;
    logic [ADDR_W-1:0] pc_d;
    logic              pipe_stall;
    logic              ie;
    logic              in_isr;
    logic              irq_ack;
    logic              flush;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_load_val;

    modport master (
        output instr_valid_d, ien_d, iof_d, rti_d, branch_d, pc_d, pipe_stall,
        input  ie, in_isr, irq_ack, flush, pc_load, pc_load_val
    );

    modport slave (
        input  instr_valid_d, ien_d, iof_d, rti_d, branch_d, pc_d, pipe_stall,
        output ie, in_isr, irq_ack, flush, pc_load, pc_load_val
    );
endinterface

// File: rtl/interrupt_controller_irq_sync.sv
// irq_sync: brings the asynchronous irq into the clk domain and flags its rising edge
module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic irq,
    output logic irq_rise
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    // shift irq through the synchroniser and remember the previous synchronised level
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], irq};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // synchroniser and edge-detector flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign irq_rise = sync_q[SYNC_STAGES-1] & ~prev_q;
endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: sequences interrupt entry (squash + vector) and RTI return for the pipeline
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int                ADDR_W       = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] VECTOR_ADDR  = ADDR_W'(VECTOR_ADDR_DEF),
    parameter int                FLUSH_CYCLES = 2,
    parameter int                SYNC_STAGES  = 2
) (
    input logic                   clk,
    input logic                   rst_n,
    input logic                   irq,
    interrupt_controller_if.slave bus
);
    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic              ie_q, ie_d;
    logic              irq_pend_q, irq_pend_d;
    logic              irq_ack_q, irq_ack_d;
    logic              flush_q, flush_d;
    logic              pc_load_q, pc_load_d;
    logic [ADDR_W-1:0] pc_load_val_q, pc_load_val_d;
    logic              in_isr_q, in_isr_d;
    logic              irq_rise;
    logic              dec_ok;
    logic              take;

    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .irq      (irq),
        .irq_rise (irq_rise)
    );

    assign dec_ok = bus.instr_valid_d & ~bus.pipe_stall;
    // only a plain, non-control-flow instruction may be squashed and replayed after return
    assign take   = (state_q == S_IDLE) & irq_pend_q & ie_q & dec_ok &
                    ~bus.branch_d & ~bus.ien_d & ~bus.iof_d & ~bus.rti_d;

    // next-state logic; outputs are derived from the next state so they come out registered
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        epc_d      = epc_q;
        ie_d       = ie_q;
        irq_pend_d = irq_rise | (irq_pend_q & ~take);
        case (state_q)
            S_IDLE: begin
                if (take) begin
                    epc_d   = bus.pc_d;
                    ie_d    = 1'b0;
                    cnt_d   = 3'(FLUSH_CYCLES - 1);
                    state_d = S_FLUSH;
                end else if (dec_ok & bus.iof_d) begin
                    ie_d = 1'b0;
                end else if (dec_ok & bus.ien_d) begin
                    ie_d = 1'b1;
                end
            end
            S_FLUSH: begin
                if (cnt_q == 3'd0) state_d = S_VECTOR;
                else cnt_d = cnt_q - 3'd1;
            end
            S_VECTOR: state_d = S_ISR;
            S_ISR:    state_d = (dec_ok & bus.rti_d) ? S_RETURN : S_ISR;
            S_RETURN: begin
                ie_d    = 1'b1;
                state_d = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
        irq_ack_d     = take;
        flush_d       = state_d inside {S_FLUSH, S_VECTOR, S_RETURN};
        pc_load_d     = state_d inside {S_VECTOR, S_RETURN};
        pc_load_val_d = (state_d == S_VECTOR) ? VECTOR_ADDR :
                        (state_d == S_RETURN) ? epc_q : pc_load_val_q;
        in_isr_d      = state_d inside {S_ISR, S_RETURN};
    end

    // state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            epc_q         <= '0;
            ie_q          <= 1'b0;
            irq_pend_q    <= 1'b0;
            irq_ack_q     <= 1'b0;
            flush_q       <= 1'b0;
            pc_load_q     <= 1'b0;
            pc_load_val_q <= '0;
            in_isr_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            epc_q         <= epc_d;
            ie_q          <= ie_d;
            irq_pend_q    <= irq_pend_d;
            irq_ack_q     <= irq_ack_d;
            flush_q       <= flush_d;
            pc_load_q     <= pc_load_d;
            pc_load_val_q <= pc_load_val_d;
            in_isr_q      <= in_isr_d;
        end
    end

    assign bus.ie          = ie_q;
    assign bus.in_isr      = in_isr_q;
    assign bus.irq_ack     = irq_ack_q;
    assign bus.flush       = flush_q;
    assign bus.pc_load     = pc_load_q;
    assign bus.pc_load_val = pc_load_val_q;
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed stimulus with a redirect/flush scoreboard checked by a monitor
module tb_interrupt_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic irq = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   run = 0;
    logic [11:0] exp_pc[$];
    int          exp_flush[$];

    interrupt_controller_if bus ();

    interrupt_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .irq   (irq),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input int a, input int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_irq();
        irq = 1'b1;
        repeat (3) step();
        irq = 1'b0;
    endtask

    task automatic wait_isr();
        int n = 0;
        while (!bus.in_isr && n < 20) begin
            step();
            n++;
        end
        chk("isr_entry", int'(bus.in_isr), 1);
    endtask

    task automatic do_rti(input logic [11:0] ret_pc);
        exp_pc.push_back(ret_pc);
        exp_flush.push_back(1);
        bus.instr_valid_d = 1'b1;
        bus.rti_d = 1'b1;
        bus.ien_d = 1'b1;
        step();
        bus.rti_d = 1'b0;
        bus.ien_d = 1'b0;
        step();
        chk("ie_after_return", int'(bus.ie), 1);
        chk("in_isr_after_return", int'(bus.in_isr), 0);
    endtask

    task automatic chk_all_zero(input string n);
        chk({n, "_ie"}, int'(bus.ie), 0);
        chk({n, "_in_isr"}, int'(bus.in_isr), 0);
        chk({n, "_irq_ack"}, int'(bus.irq_ack), 0);
        chk({n, "_flush"}, int'(bus.flush), 0);
        chk({n, "_pc_load"}, int'(bus.pc_load), 0);
        chk({n, "_pc_load_val"}, int'(bus.pc_load_val), 0);
    endtask

    // monitor: every redirect and every completed flush burst is matched against the scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            run = 0;
        end else begin
            if (bus.pc_load) begin
                if (exp_pc.size() == 0) chk("unexpected_pc_load", int'(bus.pc_load_val), -1);
                else chk("pc_load_val", int'(bus.pc_load_val), int'(exp_pc.pop_front()));
            end
            if (bus.flush) begin
                run++;
            end else if (run != 0) begin
                if (exp_flush.size() == 0) chk("unexpected_flush", run, 0);
                else chk("flush_len", run, exp_flush.pop_front());
                run = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.instr_valid_d = 1'b0;
        bus.ien_d = 1'b0;
        bus.iof_d = 1'b0;
        bus.rti_d = 1'b0;
        bus.branch_d = 1'b0;
        bus.pc_d = 12'h000;
        bus.pipe_stall = 1'b0;
        #12;
        chk_all_zero("reset");
        step();
        rst_n = 1'b1;
        step();

        // ION then an irq edge while a plain instruction at 0x040 sits in decode
        bus.instr_valid_d = 1'b1;
        bus.pc_d = 12'h040;
        bus.ien_d = 1'b1;
        step();
        bus.ien_d = 1'b0;
        chk("ion_sets_ie", int'(bus.ie), 1);
        exp_pc.push_back(12'h002);
        exp_flush.push_back(3);
        irq = 1'b1;
        repeat (3) step();
        chk("ack_not_early", int'(bus.irq_ack), 0);
        step();
        chk("ack_rise", int'(bus.irq_ack), 1);
        chk("flush_rise", int'(bus.flush), 1);
        step();
        chk("ack_one_cycle", int'(bus.irq_ack), 0);
        step();
        chk("vector_pc_load", int'(bus.pc_load), 1);
        step();
        chk("in_isr_set", int'(bus.in_isr), 1);
        chk("ie_cleared", int'(bus.ie), 0);
        chk("held_irq_no_retrigger", int'(dut.irq_pend_q), 0);
        irq = 1'b0;
        do_rti(12'h040);

        // with ie=0 a pending irq waits until after ION
        bus.iof_d = 1'b1;
        step();
        bus.iof_d = 1'b0;
        chk("iof_clears_ie", int'(bus.ie), 0);
        pulse_irq();
        repeat (4) step();
        chk("no_take_ie0_flush", int'(bus.flush), 0);
        chk("no_take_ie0_isr", int'(bus.in_isr), 0);
        bus.ien_d = 1'b1;
        step();
        bus.ien_d = 1'b0;
        bus.pc_d = 12'h055;
        exp_pc.push_back(12'h002);
        exp_flush.push_back(3);
        step();
        chk("take_after_ion", int'(bus.irq_ack), 1);
        wait_isr();
        do_rti(12'h055);

        // branch and stall in decode both block the take
        bus.instr_valid_d = 1'b0;
        pulse_irq();
        repeat (3) step();
        chk("no_take_invalid", int'(bus.irq_ack), 0);
        bus.instr_valid_d = 1'b1;
        bus.branch_d = 1'b1;
        step();
        chk("no_take_branch", int'(bus.irq_ack), 0);
        bus.branch_d = 1'b0;
        bus.pipe_stall = 1'b1;
        step();
        chk("no_take_stall", int'(bus.irq_ack), 0);
        bus.pipe_stall = 1'b0;
        bus.pc_d = 12'h077;
        exp_pc.push_back(12'h002);
        exp_flush.push_back(3);
        step();
        chk("take_after_stall", int'(bus.irq_ack), 1);
        wait_isr();
        do_rti(12'h077);

        // a second edge during the handler is taken right after return
        bus.instr_valid_d = 1'b0;
        pulse_irq();
        bus.instr_valid_d = 1'b1;
        bus.pc_d = 12'h0a0;
        exp_pc.push_back(12'h002);
        exp_flush.push_back(3);
        step();
        chk("take_first", int'(bus.irq_ack), 1);
        wait_isr();
        pulse_irq();
        bus.ien_d = 1'b1;
        step();
        bus.ien_d = 1'b0;
        chk("ion_ignored_in_isr", int'(bus.ie), 0);
        chk("pend_in_isr", int'(dut.irq_pend_q), 1);
        do_rti(12'h0a0);
        exp_pc.push_back(12'h002);
        exp_flush.push_back(3);
        step();
        chk("take_after_return", int'(bus.irq_ack), 1);
        wait_isr();
        do_rti(12'h0a0);

        // reset in the middle of the flush burst
        bus.instr_valid_d = 1'b0;
        pulse_irq();
        bus.instr_valid_d = 1'b1;
        bus.pc_d = 12'h0c0;
        step();
        chk("flush_before_reset", int'(bus.flush), 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        step();
        rst_n = 1'b1;
        step();
        bus.rti_d = 1'b1;
        bus.ien_d = 1'b1;
        step();
        bus.rti_d = 1'b0;
        bus.ien_d = 1'b0;
        chk("rti_idle_no_load", int'(bus.pc_load), 0);
        chk("rti_idle_sets_ie", int'(bus.ie), 1);
        chk("pend_discarded", int'(dut.irq_pend_q), 0);
        step();
        chk("rti_idle_no_load_late", int'(bus.pc_load), 0);

        repeat (3) step();
        chk("pc_queue_drained", exp_pc.size(), 0);
        chk("flush_queue_drained", exp_flush.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Sequences interrupt entry and return for the 16-bit RISC pipeline.
- Consumes the decode stage's interrupt strobes (ION/IOF/RTI) and the decode-stage PC, and owns the interrupt-enable flag and the saved return PC.
- On entry it squashes the pipeline and redirects fetch to the vector; on RTI it redirects fetch back to the saved PC.
- Sits between the decode stage and the fetch/PC unit.

Parameters:
- ADDR_W, 12, PC/instruction address width.
- VECTOR_ADDR, 12'h002, ISR entry address.
- FLUSH_CYCLES, 2, cycles flush is held on entry (1..7).
- SYNC_STAGES, 2, irq synchroniser depth (2..3).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- irq  in  1  external interrupt request, asynchronous to clk.
- instr_valid_d  in  1  decode holds a valid, unsquashed instruction.
- ien_d  in  1  ION (or RTI) decoded.
- iof_d  in  1  IOF decoded.
- rti_d  in  1  RTI decoded.
- branch_d  in  1  branch/BSR/RTS in decode.
- pc_d  in  ADDR_W  PC of the instruction in decode.
- pipe_stall  in  1  decode is stalled this cycle.
- ie  out  1  interrupt enable flag.
- in_isr  out  1  handler executing.
- irq_ack  out  1  one-cycle acknowledge pulse.
- flush  out  1  squash fetch/decode registers.
- pc_load  out  1  fetch must load pc_load_val next edge.
- pc_load_val  out  ADDR_W  redirect target.

Behaviour:
- Reset (async, rst_n=0): state IDLE, ie=0, in_isr=0, irq_ack=0, flush=0, pc_load=0, pc_load_val=0, epc=0, irq_pend=0, synchroniser cleared.
- Decode strobe qualifier: dec_ok = instr_valid_d & !pipe_stall.
- irq passes through SYNC_STAGES flops to give irq_s. A rising edge of irq_s sets irq_pend the following edge, so irq_pend is seen SYNC_STAGES+1 cycles after irq rises.
- irq_pend clears only on take. If a new edge coincides with the take, the set wins and irq_pend stays 1.
- The ie flag is updated only while in IDLE:
  - dec_ok & ien_d -> ie=1.
  - dec_ok & iof_d -> ie=0.
  - ien_d and iof_d together -> iof wins.
- States: IDLE, FLUSH, VECTOR, ISR, RETURN.
- IDLE:
  - take = irq_pend & ie & dec_ok & !branch_d & !ien_d & !iof_d & !rti_d.
  - On take: epc<=pc_d (the decode instruction is squashed and re-executed after return), ie<=0, irq_pend<=0, irq_ack=1 for that cycle, flush=1, counter<=FLUSH_CYCLES-1, go to FLUSH.
  - An RTI in IDLE is not an interrupt return: no redirect; only its ien_d sets ie.
- FLUSH: flush=1 every cycle; counter decrements; at 0 go to VECTOR. flush is therefore high for FLUSH_CYCLES consecutive cycles, ignoring pipe_stall.
- VECTOR: one cycle with flush=1, pc_load=1, pc_load_val=VECTOR_ADDR; next state ISR.
- ISR:
  - in_isr=1.
  - ien_d and iof_d are ignored; ie stays 0 (no nesting).
  - New irq edges still set irq_pend.
  - dec_ok & rti_d -> RETURN.
- RETURN: one cycle with flush=1, pc_load=1, pc_load_val=epc, ie<=1, in_isr=0 from the next cycle; next state IDLE.
- A pending irq is taken in IDLE at the earliest valid instruction after RETURN, i.e. the first refetched instruction at epc.
- Outputs flush, pc_load, pc_load_val and irq_ack are registered (Moore on state/counter). pc_load_val holds its last value when pc_load=0.
- Latency:
  - take cycle to pc_load = FLUSH_CYCLES+1 edges.
  - RTI in decode to pc_load = 1 edge.
- Reset mid-sequence (any state) returns to IDLE and discards epc and the pending request.
- irq held high does not retrigger; only a new rising edge does.

Decomposition:
- Shared package: state encoding constants (IDLE=0, FLUSH=1, VECTOR=2, ISR=3, RETURN=4), VECTOR_ADDR default, ADDR_W.
- One sub-module: irq_sync, containing the SYNC_STAGES synchroniser plus the rising-edge detector, with output irq_rise.

Test Plan:
- Reset, then an ION with dec_ok, then irq rises at cycle 10 while pc_d=12'h040 and no branch.
  - irq_ack and flush rise at cycle 13.
  - flush is high for 3 cycles (FLUSH_CYCLES=2 plus VECTOR).
  - pc_load=1 with pc_load_val=12'h002 at cycle 15.
  - in_isr=1 from cycle 16; ie=0.
- In ISR, RTI decoded with dec_ok: next cycle pc_load=1, pc_load_val=12'h040, flush=1; then ie=1, in_isr=0, state IDLE.
- ie=0, then irq pulses: no take. After ION, the first dec_ok non-branch instruction with pc_d=12'h055 causes the take, and epc=12'h055.
- Pending irq with branch_d=1 then pipe_stall=1: no take in either cycle. The take occurs on the next cycle with dec_ok and branch_d=0.
- Second irq edge during ISR: irq_pend=1 while in ISR, ION ignored (ie stays 0). After RETURN, the take happens on the first dec_ok cycle and pc_load_val=VECTOR_ADDR again.
- rst_n asserted in FLUSH: all outputs 0 immediately. After release, an RTI in IDLE produces no pc_load and ie=1.
